// File: rtl/issue_queue_pkg.sv
// Shared types for the issue queue: renamed instruction, physical register
// tag, branch resolution, and the queue entry wrapper.
package issue_queue_pkg;

  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
  } p_reg_t;

  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] op;
    p_reg_t     rs1;
    logic       rs1_ready;
    p_reg_t     rs2;
    logic       rs2_ready;
    p_reg_t     rd;
  } rinstr_t;

  typedef struct packed {
    rinstr_t instr;
    logic    spec;
  } iq_entry_t;

  // p0 is hardwired zero, so it never waits on a writeback
  function automatic logic src_ready(input p_reg_t src, input logic rdy);
    return !src.valid || (src.idx == 6'd0) || rdy;
  endfunction

  function automatic logic instr_ready(input rinstr_t in);
    return src_ready(in.rs1, in.rs1_ready) && src_ready(in.rs2, in.rs2_ready);
  endfunction

  function automatic rinstr_t wakeup(input rinstr_t in, input p_reg_t wb);
    rinstr_t o;
    o = in;
    if (wb.valid && in.rs1.valid && (in.rs1.idx == wb.idx)) o.rs1_ready = 1'b1;
    if (wb.valid && in.rs2.valid && (in.rs2.idx == wb.idx)) o.rs2_ready = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/iq_select.sv
// Oldest-ready picker: lowest set request bit wins.
module iq_select #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from youngest to oldest so the oldest request overwrites the result
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = |req_i;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Collapsing, age-ordered issue queue with writeback wakeup and
// single-branch speculation squash. Slot 0 always holds the oldest entry.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  rinstr_t          rinstr_i,
  input  logic             is_branch_i,
  output logic             iq_stall_o,
  input  p_reg_t           wb_i,
  input  br_result_t       br_result_i,
  output rinstr_t          issue_o,
  input  logic             issue_ready_i,
  output logic [CNT_W-1:0] count_o
);

  localparam int IDX_W = $clog2(DEPTH);

  iq_entry_t        entries_q [DEPTH];
  iq_entry_t        entries_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d, pos;
  logic             br_pending_q, br_pending_d;
  logic             mispredict, br_hit, accept, insert, fire;
  logic [DEPTH-1:0] occ, squash, req, grant;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;

  assign mispredict = br_pending_q && br_result_i.valid && !br_result_i.hit;
  assign br_hit     = br_pending_q && br_result_i.valid && br_result_i.hit;
  assign iq_stall_o = (count_q == CNT_W'(DEPTH)) ||
                      (is_branch_i && br_pending_q && !br_result_i.valid);
  assign accept     = rinstr_i.valid && !iq_stall_o;
  // An instruction arriving with a mispredict would be speculative, so it dies
  assign insert     = accept && !mispredict;
  assign count_o    = count_q;

  // Occupancy, squash mask and issue requests per slot
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      occ[i]    = CNT_W'(i) < count_q;
      squash[i] = mispredict && entries_q[i].spec;
      req[i]    = occ[i] && !squash[i] && instr_ready(entries_q[i].instr);
    end
  end

  iq_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
    .req_i   (req),
    .grant_o (grant),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  // Present the selected entry; all-zero when nothing is ready
  always_comb begin
    issue_o = '0;
    if (sel_valid) begin
      issue_o       = entries_q[sel_idx].instr;
      issue_o.valid = 1'b1;
    end
  end

  assign fire = sel_valid && issue_ready_i;

  // Next state: compact survivors, append insert, then apply wakeup and hit
  always_comb begin
    pos = '0;
    for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && !squash[i] && !(fire && grant[i])) begin
        entries_d[pos[IDX_W-1:0]] = entries_q[i];
        pos = pos + CNT_W'(1);
      end
    end
    // insert implies not full, so pos < DEPTH here
    if (insert) begin
      entries_d[pos[IDX_W-1:0]].instr = rinstr_i;
      entries_d[pos[IDX_W-1:0]].spec  = br_pending_q && !br_hit;
      pos = pos + CNT_W'(1);
    end
    count_d = pos;
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i].instr = wakeup(entries_d[i].instr, wb_i);
      if (br_hit) entries_d[i].spec = 1'b0;
    end
    br_pending_d = br_pending_q;
    if (br_result_i.valid) br_pending_d = 1'b0;
    if (insert && is_branch_i) br_pending_d = 1'b1;
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q      <= '0;
      br_pending_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      count_q      <= count_d;
      br_pending_q <= br_pending_d;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  rinstr_t    rinstr;
  logic       is_branch;
  logic       iq_stall;
  p_reg_t     wb;
  br_result_t br_result;
  rinstr_t    issue;
  logic       issue_ready;
  logic [3:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int sb_exp;

  typedef struct {
    logic [5:0] s1; logic s1v; logic s1r;
    logic [5:0] s2; logic s2v; logic s2r;
    logic [5:0] rd; logic exp_rdy;
  } vec_t;
  vec_t vecs[6];

  issue_queue dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rinstr_i      (rinstr),
    .is_branch_i   (is_branch),
    .iq_stall_o    (iq_stall),
    .wb_i          (wb),
    .br_result_i   (br_result),
    .issue_o       (issue),
    .issue_ready_i (issue_ready),
    .count_o       (count)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every transfer must match the next expected rd
  always @(negedge clk_i) begin
    if (rst_ni && issue.valid && issue_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got rd %0d expected none", issue.rd.idx);
      end else begin
        sb_exp = exp_q.pop_front();
        if (int'(issue.rd.idx) != sb_exp) begin
          n_fail++;
          $display("FAIL sb_order: got rd %0d expected %0d", issue.rd.idx, sb_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    rinstr = '0; is_branch = 1'b0; wb = '0; br_result = '0; issue_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  function automatic rinstr_t mk(input logic [5:0] s1, input logic s1v, input logic s1r,
                                 input logic [5:0] s2, input logic s2v, input logic s2r,
                                 input logic [5:0] rd);
    rinstr_t r;
    r = '0;
    r.valid = 1'b1;
    r.rs1.valid = s1v; r.rs1.idx = s1; r.rs1_ready = s1r;
    r.rs2.valid = s2v; r.rs2.idx = s2; r.rs2_ready = s2r;
    r.rd.valid = 1'b1; r.rd.idx = rd;
    return r;
  endfunction

  task automatic ins(input rinstr_t r, input logic br);
    rinstr = r; is_branch = br;
    step();
    rinstr = '0; is_branch = 1'b0;
  endtask

  // Branch at slot 1 followed by three speculative entries, none ready
  task automatic branch_setup();
    ins(mk(6'd30, 1, 0, 6'd0, 0, 0, 6'd1), 1'b0);
    ins(mk(6'd31, 1, 0, 6'd0, 0, 0, 6'd2), 1'b1);
    for (int i = 0; i < 3; i++) ins(mk(6'(32 + i), 1, 0, 6'd0, 0, 0, 6'(3 + i)), 1'b0);
  endtask

  initial begin
    logic [5:0] w;
    vecs[0] = '{6'd1,  1, 1, 6'd2,  1, 1, 6'd32, 1};
    vecs[1] = '{6'd0,  1, 0, 6'd0,  0, 0, 6'd33, 1};
    vecs[2] = '{6'd5,  1, 0, 6'd0,  0, 0, 6'd34, 0};
    vecs[3] = '{6'd0,  0, 0, 6'd7,  1, 0, 6'd35, 0};
    vecs[4] = '{6'd9,  1, 1, 6'd10, 1, 0, 6'd36, 0};
    vecs[5] = '{6'd0,  0, 0, 6'd0,  0, 0, 6'd37, 1};

    do_reset();
    @(negedge clk_i);
    chk("rst_count", count, 0);
    chk("rst_stall", iq_stall, 0);
    chk("rst_issue_valid", issue.valid, 0);

    // Single-instruction readiness vectors
    for (int k = 0; k < 6; k++) begin
      step();
      rinstr = mk(vecs[k].s1, vecs[k].s1v, vecs[k].s1r, vecs[k].s2, vecs[k].s2v,
                  vecs[k].s2r, vecs[k].rd);
      step();
      rinstr = '0;
      @(negedge clk_i);
      chk($sformatf("vec%0d_ready", k), issue.valid, vecs[k].exp_rdy);
      chk($sformatf("vec%0d_count1", k), count, 1);
      if (!vecs[k].exp_rdy) begin
        w = (vecs[k].s1v && !vecs[k].s1r && vecs[k].s1 != 0) ? vecs[k].s1 : vecs[k].s2;
        step();
        wb = '{valid: 1'b1, idx: w};
        step();
        wb = '0;
        @(negedge clk_i);
        chk($sformatf("vec%0d_woken", k), issue.valid, 1);
      end
      step();
      issue_ready = 1'b1;
      exp_q.push_back(int'(vecs[k].rd));
      step();
      issue_ready = 1'b0;
      @(negedge clk_i);
      chk($sformatf("vec%0d_count0", k), count, 0);
    end

    // Younger ready instruction bypasses an older blocked one
    do_reset();
    ins(mk(6'd40, 1, 0, 6'd0, 0, 0, 6'd11), 1'b0);
    ins(mk(6'd3, 1, 1, 6'd4, 1, 1, 6'd12), 1'b0);
    @(negedge clk_i);
    chk("age_first_rd", issue.rd.idx, 12);
    step();
    issue_ready = 1'b1;
    exp_q.push_back(12);
    step();
    wb = '{valid: 1'b1, idx: 6'd40};
    @(negedge clk_i);
    chk("wake_not_same_cycle", issue.valid, 0);
    step();
    wb = '0;
    exp_q.push_back(11);
    step();
    issue_ready = 1'b0;
    @(negedge clk_i);
    chk("age_count0", count, 0);

    // Full queue stalls; issuing a woken middle slot frees space
    do_reset();
    for (int i = 0; i < 8; i++) ins(mk(6'(20 + i), 1, 0, 6'd0, 0, 0, 6'(50 + i)), 1'b0);
    @(negedge clk_i);
    chk("full_count", count, 8);
    chk("full_stall", iq_stall, 1);
    step();
    rinstr = mk(6'd1, 1, 1, 6'd2, 1, 1, 6'd60);
    @(negedge clk_i);
    chk("full_stall_req", iq_stall, 1);
    step();
    rinstr = '0;
    wb = '{valid: 1'b1, idx: 6'd23};
    @(negedge clk_i);
    chk("full_no_accept", count, 8);
    step();
    wb = '0;
    @(negedge clk_i);
    chk("full_slot3_rd", issue.rd.idx, 53);
    step();
    issue_ready = 1'b1;
    exp_q.push_back(53);
    step();
    issue_ready = 1'b0;
    @(negedge clk_i);
    chk("full_unstall", iq_stall, 0);
    chk("full_count7", count, 7);

    // Mispredict squashes speculative entries and a same-cycle insert
    do_reset();
    branch_setup();
    @(negedge clk_i);
    chk("br_count5", count, 5);
    step();
    rinstr = mk(6'd1, 1, 1, 6'd0, 0, 0, 6'd8);
    is_branch = 1'b1;
    @(negedge clk_i);
    chk("br_second_stall", iq_stall, 1);
    step();
    is_branch = 1'b0;
    rinstr = mk(6'd1, 1, 1, 6'd0, 0, 0, 6'd9);
    br_result = '{valid: 1'b1, hit: 1'b0};
    step();
    rinstr = '0;
    br_result = '0;
    @(negedge clk_i);
    chk("mis_count2", count, 2);
    step();
    wb = '{valid: 1'b1, idx: 6'd30};
    step();
    wb = '{valid: 1'b1, idx: 6'd31};
    step();
    wb = '0;
    issue_ready = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(2);
    step();
    step();
    issue_ready = 1'b0;
    @(negedge clk_i);
    chk("mis_drained", count, 0);

    // Correct prediction keeps everything and clears spec bits
    do_reset();
    branch_setup();
    br_result = '{valid: 1'b1, hit: 1'b1};
    step();
    br_result = '0;
    @(negedge clk_i);
    chk("hit_count5", count, 5);
    step();
    rinstr = mk(6'd1, 1, 1, 6'd0, 0, 0, 6'd6);
    is_branch = 1'b1;
    @(negedge clk_i);
    chk("hit_no_stall", iq_stall, 0);
    step();
    rinstr = '0;
    is_branch = 1'b0;
    br_result = '{valid: 1'b1, hit: 1'b0};
    step();
    br_result = '0;
    @(negedge clk_i);
    chk("hit_spec_cleared", count, 6);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_issue", issue.valid, 0);

    // Same-cycle writeback bypass at insert
    do_reset();
    rinstr = mk(6'd45, 1, 0, 6'd0, 0, 0, 6'd7);
    wb = '{valid: 1'b1, idx: 6'd45};
    step();
    rinstr = '0;
    wb = '0;
    @(negedge clk_i);
    chk("bypass_valid", issue.valid, 1);
    chk("bypass_rd", issue.rd.idx, 7);
    step();
    issue_ready = 1'b1;
    exp_q.push_back(7);
    step();
    issue_ready = 1'b0;
    @(negedge clk_i);
    chk("bypass_count0", count, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
